// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl -- sequencing controller for an add/shift signed multiplier.
//
// Walks the datapath through WIDTH iterations of (conditional add, arithmetic
// shift) over X:A:B. The last iteration subtracts instead of adding, because
// the MSB of a two's-complement multiplier carries negative weight.
//
// Optional feature, selected by the macro MULT_AUTO_CLEAR_EN:
//   defined   - every run starts with a one-cycle ClearA pulse, so the result is
//               S*B from zero.
//   undefined - no clear state; A accumulates across consecutive runs so the
//               operator can chain multiplies. ClearA is tied low.
//
// Ports
//   Clk           system clock, rising edge
//   Reset         synchronous, active-high; forces IDLE from any state
//   Run           start request (level); one multiply per assertion
//   ClearA_LoadB  operator request: clear A/X and load B (honoured in IDLE only)
//   M             current LSB of the B register
//   Clr_Ld        strobe: clear A/X, load B
//   ClearA        strobe: clear A and X only
//   Add           strobe: A/X <= A + S
//   Sub           strobe: A/X <= A - S (final iteration)
//   Shift         strobe: arithmetic right shift of X:A:B
//   Busy          sequence in progress (CLR, ADD, SHIFT)
//   Done          result valid; held until Run is released
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Run; ClearA_LoadB passes through as Clr_Ld
// CLR   | one-cycle clear of A/X before the first add (auto-clear build)
// ADD   | add or subtract S depending on M and the iteration number
// SHIFT | shift X:A:B right; advance iteration or finish
// DONE  | result valid; wait for Run to drop so one press = one multiply

module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic ClearA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        DONE
    } state_t;

`ifdef MULT_AUTO_CLEAR_EN
    localparam state_t FIRST = CLR;
`else
    localparam state_t FIRST = ADD;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            last_iter;

    assign last_iter = (count == LAST);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (Run) begin
                    state_nxt = FIRST;
                    count_nxt = '0;
                end
            end
            CLR:   state_nxt = ADD;
            ADD:   state_nxt = SHIFT;
            SHIFT: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end else begin
                    count_nxt = count + 1'b1;
                    state_nxt = ADD;
                end
            end
            DONE: begin
                if (!Run) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift/Busy/Done (and ClearA) are registered from the next state, so they
    // are glitch-free and line up exactly with the state they describe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            count  <= '0;
            Shift  <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
`ifdef MULT_AUTO_CLEAR_EN
            ClearA <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            Shift  <= (state_nxt == SHIFT);
            Busy   <= (state_nxt == CLR) || (state_nxt == ADD) || (state_nxt == SHIFT);
            Done   <= (state_nxt == DONE);
`ifdef MULT_AUTO_CLEAR_EN
            ClearA <= (state_nxt == CLR);
`endif
        end
    end

`ifndef MULT_AUTO_CLEAR_EN
    assign ClearA = 1'b0;
`endif

    // These depend on M (which moves with every shift) or on operator inputs,
    // so they are decoded combinationally from the current state. Reset masks
    // them so nothing reaches the datapath while reset is held.
    assign Add    = ~Reset & (state == ADD) & M & ~last_iter;
    assign Sub    = ~Reset & (state == ADD) & M &  last_iter;
    assign Clr_Ld = ~Reset & (state == IDLE) & ClearA_LoadB & ~Run;

endmodule
